guess_checker: RTL and testbench

GUESS_CHECKER -- requirements
Module: guess_checker

---
 rtl/guess_checker.sv | 83 ++++++++
 tb/tb_guess_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/guess_checker.sv
// guess_checker: number-guessing game; each accepted guess is latched, then judged
// against secret during a single CHECK cycle. All state advances on the falling clock edge.
module guess_checker #(
    parameter int MAX_TRIES = 5
) (
    input  logic       clk,
    input  logic       rts,
    input  logic       enable,
    input  logic       guess_valid,
    input  logic [3:0] guess,
    input  logic [3:0] secret,
    output logic       busy,
    output logic       too_high,
    output logic       too_low,
    output logic       win,
    output logic       lose,
    output logic [3:0] tries_left
);
    localparam logic [3:0] MAX = 4'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, CHECK, WIN, LOSE} state_t;

    state_t     state_q = IDLE, state_d;
    logic [3:0] guess_q = '0, guess_d;
    logic [3:0] tries_q = MAX, tries_d;
    logic       hi_q = 1'b0, hi_d;
    logic       lo_q = 1'b0, lo_d;
    logic       win_q = 1'b0, win_d;
    logic       lose_q = 1'b0, lose_d;

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        tries_d = tries_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        win_d   = win_q;
        lose_d  = lose_q;
        case (state_q)
            IDLE: if (guess_valid && enable) begin
                guess_d = guess;
                state_d = CHECK;
            end
            CHECK: begin
                // equality wins over exhaustion, so a match on the last try is a win
                tries_d = (tries_q == 4'd0) ? 4'd0 : tries_q - 4'd1;
                hi_d    = guess_q > secret;
                lo_d    = guess_q < secret;
                win_d   = guess_q == secret;
                lose_d  = (guess_q != secret) && (tries_q <= 4'd1);
                state_d = win_d ? WIN : lose_d ? LOSE : IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rts) begin
            state_q <= IDLE;
            guess_q <= '0;
            tries_q <= MAX;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guess_q <= guess_d;
            tries_q <= tries_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign busy       = state_q == CHECK;
    assign too_high   = hi_q;
    assign too_low    = lo_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign tries_left = tries_q;
endmodule

// File: tb/tb_guess_checker.sv
// tb_guess_checker: directed game scenarios plus randomized play against a game-level model.
module tb_guess_checker;
    logic       clk = 1'b0;
    logic       rts = 1'b0, enable = 1'b0, guess_valid = 1'b0;
    logic [3:0] guess = '0, secret = '0;
    logic       busy, too_high, too_low, win, lose;
    logic [3:0] tries_left;

    int checks = 0, failures = 0;

    // model: a game with at most one guess awaiting judgement
    int m_tries = 5, m_pend = -1;
    bit m_win = 0, m_lose = 0, m_hi = 0, m_lo = 0;

    guess_checker #(.MAX_TRIES(5)) dut (
        .clk(clk), .rts(rts), .enable(enable), .guess_valid(guess_valid),
        .guess(guess), .secret(secret), .busy(busy), .too_high(too_high),
        .too_low(too_low), .win(win), .lose(lose), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit e, input bit v, input logic [3:0] g, input logic [3:0] s);
        rts = r; enable = e; guess_valid = v; guess = g; secret = s;
        @(negedge clk);
        if (r) begin
            m_tries = 5; m_pend = -1; m_win = 0; m_lose = 0; m_hi = 0; m_lo = 0;
        end else if (m_pend >= 0) begin
            if (m_pend == int'(s)) begin
                m_win = 1; m_hi = 0; m_lo = 0;
            end else begin
                m_hi = m_pend > int'(s); m_lo = m_pend < int'(s);
                if (m_tries == 1) m_lose = 1;
            end
            m_tries = m_tries - 1;
            m_pend = -1;
        end else if (!m_win && !m_lose && v && e) begin
            m_pend = int'(g);
        end
        #1;
    endtask

    task automatic guess_once(input logic [3:0] g, input logic [3:0] s);
        step(0, 1, 1, g, s);
        step(0, 1, 0, g, s);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_0000_0101) begin
            failures++; $display("FAIL powerup got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_0000_0101);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_0000_0101) begin
            failures++; $display("FAIL reset got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_0000_0101);
        end
    endtask

    task automatic test_win;
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 9, 9);
        checks++;
        if ({busy, win, tries_left} !== 6'b1_0_0101) begin
            failures++; $display("FAIL win_check_cycle got=%b exp=%b", {busy, win, tries_left}, 6'b1_0_0101);
        end
        step(0, 1, 0, 9, 9);
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_0010_0100) begin
            failures++; $display("FAIL win got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_0010_0100);
        end
    endtask

    task automatic test_low_high;
        step(1, 0, 0, 0, 0);
        guess_once(2, 6);
        checks++;
        if ({too_high, too_low, tries_left} !== 6'b01_0100) begin
            failures++; $display("FAIL too_low got=%b exp=%b", {too_high, too_low, tries_left}, 6'b01_0100);
        end
        guess_once(12, 6);
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_1000_0011) begin
            failures++; $display("FAIL too_high got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_1000_0011);
        end
        step(0, 1, 1, 6, 6);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL back_in_idle got=%b exp=1", busy);
        end
        step(0, 1, 0, 6, 6);
    endtask

    task automatic test_lose;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] g;
            g = 4'($urandom_range(4, 15));
            guess_once(g, 3);
        end
        checks++;
        if ({win, lose, tries_left} !== 6'b01_0000) begin
            failures++; $display("FAIL lose got=%b exp=%b", {win, lose, tries_left}, 6'b01_0000);
        end
        guess_once(3, 3);
        checks++;
        if ({busy, win, lose, tries_left} !== 7'b0_01_0000) begin
            failures++; $display("FAIL lose_terminal got=%b exp=%b", {busy, win, lose, tries_left}, 7'b0_01_0000);
        end
    endtask

    task automatic test_last_try_win;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) guess_once(4'($urandom_range(0, 2)), 3);
        guess_once(3, 3);
        checks++;
        if ({too_high, too_low, win, lose, tries_left} !== 8'b0010_0000) begin
            failures++; $display("FAIL last_try_win got=%b exp=%b", {too_high, too_low, win, lose, tries_left}, 8'b0010_0000);
        end
    endtask

    task automatic test_enable_and_drop;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 5, 7);
        step(0, 0, 0, 5, 7);
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_0000_0101) begin
            failures++; $display("FAIL enable_low got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_0000_0101);
        end
        step(0, 1, 1, 5, 7);
        step(0, 1, 1, 9, 7);
        step(0, 1, 0, 9, 7);
        checks++;
        if ({busy, too_high, too_low, tries_left} !== 7'b0_01_0100) begin
            failures++; $display("FAIL drop_in_check got=%b exp=%b", {busy, too_high, too_low, tries_left}, 7'b0_01_0100);
        end
        step(0, 1, 0, 9, 2);
        checks++;
        if ({too_high, too_low} !== 2'b01) begin
            failures++; $display("FAIL secret_outside_check got=%b exp=01", {too_high, too_low});
        end
    endtask

    task automatic test_reset_priority;
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 8);
        step(1, 1, 0, 1, 8);
        checks++;
        if ({busy, too_high, too_low, win, lose, tries_left} !== 9'b0_0000_0101) begin
            failures++; $display("FAIL rts_in_check got=%b exp=%b", {busy, too_high, too_low, win, lose, tries_left}, 9'b0_0000_0101);
        end
        guess_once(8, 8);
        step(1, 1, 0, 0, 8);
        checks++;
        if ({busy, win, lose, tries_left} !== 7'b0_00_0101) begin
            failures++; $display("FAIL rts_in_win got=%b exp=%b", {busy, win, lose, tries_left}, 7'b0_00_0101);
        end
        step(0, 1, 1, 2, 8);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL idle_after_rts got=%b exp=1", busy);
        end
    endtask

    task automatic test_random;
        logic [8:0] exp;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 4'($urandom), 4'($urandom_range(0, 7)));
            exp = {m_pend >= 0, m_hi, m_lo, m_win, m_lose, 4'(m_tries)};
            checks++;
            if ({busy, too_high, too_low, win, lose, tries_left} !== exp) begin
                failures++; $display("FAIL random[%0d] got=%b exp=%b", i, {busy, too_high, too_low, win, lose, tries_left}, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_win;
        test_low_high;
        test_lose;
        test_last_try_win;
        test_enable_and_drop;
        test_reset_priority;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
